ddr_frame_arbiter: RTL and testbench

DDR_FRAME_ARBITER -- requirements
Module: ddr_frame_arbiter

---
 rtl/ddr_frame_arbiter_if.sv | 36 +++
 rtl/ddr_frame_arbiter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ddr_frame_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_frame_arbiter_if.sv
// ddr_frame_arbiter_if
// Native user-interface bundle between the frame arbiter and the memory
// controller.
//   master modport : arbiter side (drives command, address and write data)
//   slave modport  : controller side (drives ready flags and read return)
// Signals:
//   app_addr, app_cmd, app_en       command channel (000 = write, 001 = read)
//   app_wdf_data, app_wdf_wren,
//   app_wdf_end                     write-data channel
//   app_rdy, app_wdf_rdy            controller ready flags
//   app_rd_data, app_rd_data_valid  read return
interface ddr_frame_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr_frame_arbiter.sv
// ddr_frame_arbiter
// Shares one memory-controller port between NUM_WR round-robin write
// requesters and a frame reader that keeps a two-half ping-pong buffer
// filled. Reader work (refill, then priming) takes precedence over writes.
// Ports:
//   clk, sys_rst (async, active-low), calib_done
//   wr_req/wr_addr/wr_data/wr_ack     per-channel write requesters
//   rd_enable, refill_req/refill_half/refill_ack, primed, buf_data,
//   frame_wrap                        frame reader / ping-pong buffer
//   app                               controller interface (master side)
module ddr_frame_arbiter #(
  parameter int NUM_WR      = 2,
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 128,
  parameter int HALF_WORDS  = 5,
  parameter int FRAME_WORDS = 98304,
  parameter int ADDR_STEP   = 8
) (
  input  logic                           clk,
  input  logic                           sys_rst,
  input  logic                           calib_done,
  input  logic [NUM_WR-1:0]              wr_req,
  input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]       wr_data,
  output logic [NUM_WR-1:0]              wr_ack,
  input  logic                           rd_enable,
  input  logic                           refill_req,
  input  logic                           refill_half,
  output logic                           refill_ack,
  output logic                           primed,
  output logic [2*HALF_WORDS*DATA_W-1:0] buf_data,
  output logic                           frame_wrap,
  ddr_frame_arbiter_if.master            app
);

  localparam int GW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int CW = $clog2(HALF_WORDS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((FRAME_WORDS - 1) * ADDR_STEP);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    WRITE_DONE = 3'd2,
    RD_ISSUE   = 3'd3,
    RD_DRAIN   = 3'd4
  } state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     rr_ptr;          // channel where the next search starts
  logic [ADDR_W-1:0] rd_addr;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     ret_cnt;
  logic              fill_half;
  logic              fill_refill;     // current fill serves a refill (else priming)
  logic              refill_pending;
  logic              refill_pend_half;
  logic              refill_active;
  logic              prime_stage;     // 0: priming half 0 next, 1: half 1 next

  logic [GW-1:0]     pick;
  logic [GW-1:0]     pick_next;
  logic              pick_valid;
  int                cand;
  logic [ADDR_W-1:0] next_addr;
  logic              at_last;
  logic [ADDR_W-1:0] prime_addr;
  logic              ret_take;
  logic              refill_take;
  int                buf_idx;

  assign app.app_wdf_end = 1'b1;

  // Round-robin pick: first requesting channel at or after rr_ptr.
  always_comb begin
    pick       = {GW{1'b0}};
    pick_valid = 1'b0;
    cand       = 0;
    for (int k = 0; k < NUM_WR; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_WR;
      if (!pick_valid && wr_req[cand[GW-1:0]]) begin
        pick_valid = 1'b1;
        pick       = cand[GW-1:0];
      end else begin
        pick_valid = pick_valid;
      end
    end
    if (pick == GW'(NUM_WR - 1)) begin
      pick_next = {GW{1'b0}};
    end else begin
      pick_next = pick + GW'(1);
    end
  end

  // Read-address sequencing, return capture and refill-latch qualifiers.
  always_comb begin
    at_last = (rd_addr == LAST_ADDR);
    if (at_last) begin
      next_addr = {ADDR_W{1'b0}};
    end else begin
      next_addr = rd_addr + ADDR_W'(ADDR_STEP);
    end
    // The first priming fill restarts the frame; the second continues it.
    if (prime_stage) begin
      prime_addr = rd_addr;
    end else begin
      prime_addr = {ADDR_W{1'b0}};
    end
    // Returns are counted only inside a fill, and extras are dropped.
    ret_take = ((state == RD_ISSUE) || (state == RD_DRAIN)) &&
               app.app_rd_data_valid && (ret_cnt < CW'(HALF_WORDS));
    buf_idx  = (fill_half ? HALF_WORDS : 0) + int'(ret_cnt);
    // The ack cycle is excluded so a level request still high while the
    // consumer sees refill_ack cannot start a second refill.
    refill_take = refill_req && primed && !refill_pending && !refill_active && !refill_ack;
  end

  // Ping-pong buffer storage, written as read data returns.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      buf_data <= {(2*HALF_WORDS*DATA_W){1'b0}};
    end else if (ret_take) begin
      buf_data[buf_idx*DATA_W +: DATA_W] <= app.app_rd_data;
    end else begin
      buf_data <= buf_data;
    end
  end

  // Main arbitration FSM with registered controller outputs and pulses.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state            <= IDLE;
      grant            <= {GW{1'b0}};
      rr_ptr           <= {GW{1'b0}};
      rd_addr          <= {ADDR_W{1'b0}};
      issue_cnt        <= {CW{1'b0}};
      ret_cnt          <= {CW{1'b0}};
      fill_half        <= 1'b0;
      fill_refill      <= 1'b0;
      refill_pending   <= 1'b0;
      refill_pend_half <= 1'b0;
      refill_active    <= 1'b0;
      prime_stage      <= 1'b0;
      primed           <= 1'b0;
      wr_ack           <= {NUM_WR{1'b0}};
      refill_ack       <= 1'b0;
      frame_wrap       <= 1'b0;
      app.app_addr     <= {ADDR_W{1'b0}};
      app.app_cmd      <= 3'b000;
      app.app_en       <= 1'b0;
      app.app_wdf_data <= {DATA_W{1'b0}};
      app.app_wdf_wren <= 1'b0;
    end else begin
      wr_ack     <= {NUM_WR{1'b0}};
      refill_ack <= 1'b0;
      frame_wrap <= 1'b0;
      if (!rd_enable) begin
        primed <= 1'b0;
      end
      if (refill_take) begin
        refill_pending   <= 1'b1;
        refill_pend_half <= refill_half;
      end
      if (ret_take) begin
        ret_cnt <= ret_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (!rd_enable) begin
            prime_stage <= 1'b0;
          end
          if (!calib_done) begin
            state <= IDLE;
          end else if (refill_pending) begin
            refill_pending <= 1'b0;
            refill_active  <= 1'b1;
            fill_refill    <= 1'b1;
            fill_half      <= refill_pend_half;
            issue_cnt      <= {CW{1'b0}};
            ret_cnt        <= {CW{1'b0}};
            app.app_addr   <= rd_addr;
            app.app_cmd    <= 3'b001;
            app.app_en     <= 1'b1;
            state          <= RD_ISSUE;
          end else if (rd_enable && !primed) begin
            fill_refill  <= 1'b0;
            fill_half    <= prime_stage;
            issue_cnt    <= {CW{1'b0}};
            ret_cnt      <= {CW{1'b0}};
            rd_addr      <= prime_addr;
            app.app_addr <= prime_addr;
            app.app_cmd  <= 3'b001;
            app.app_en   <= 1'b1;
            state        <= RD_ISSUE;
          end else if (pick_valid) begin
            grant            <= pick;
            rr_ptr           <= pick_next;
            app.app_addr     <= wr_addr[int'(pick)*ADDR_W +: ADDR_W];
            app.app_wdf_data <= wr_data[int'(pick)*DATA_W +: DATA_W];
            state            <= WRITE;
          end else begin
            state <= IDLE;
          end
        end

        WRITE: begin
          if (app.app_rdy && app.app_wdf_rdy) begin
            app.app_cmd      <= 3'b000;
            app.app_en       <= 1'b1;
            app.app_wdf_wren <= 1'b1;
            state            <= WRITE_DONE;
          end
        end

        WRITE_DONE: begin
          // Command and data channels retire independently.
          if (app.app_en && app.app_rdy) begin
            app.app_en <= 1'b0;
          end
          if (app.app_wdf_wren && app.app_wdf_rdy) begin
            app.app_wdf_wren <= 1'b0;
          end
          if (!app.app_en && !app.app_wdf_wren) begin
            wr_ack[grant] <= 1'b1;
            state         <= IDLE;
          end
        end

        RD_ISSUE: begin
          if (app.app_rdy) begin
            issue_cnt    <= issue_cnt + CW'(1);
            rd_addr      <= next_addr;
            app.app_addr <= next_addr;
            frame_wrap   <= at_last;
            if (issue_cnt == CW'(HALF_WORDS - 1)) begin
              app.app_en <= 1'b0;
              state      <= RD_DRAIN;
            end
          end
        end

        RD_DRAIN: begin
          if (ret_cnt == CW'(HALF_WORDS)) begin
            state <= IDLE;
            if (fill_refill) begin
              refill_ack    <= 1'b1;
              refill_active <= 1'b0;
            end else if (!fill_half) begin
              // Half 0 primed: the next IDLE pass fills half 1.
              prime_stage <= rd_enable;
            end else begin
              primed      <= rd_enable;
              prime_stage <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Self-checking bench for ddr_frame_arbiter: a single process drives and
// samples on the falling edge, acts as the memory controller (read data
// returned 3 cycles after each accepted read) and compares DUT activity
// against queued expectations.
module tb_ddr_frame_arbiter;
  localparam int NUM_WR      = 2;
  localparam int ADDR_W      = 28;
  localparam int DATA_W      = 128;
  localparam int HALF_WORDS  = 5;
  localparam int FRAME_WORDS = 16;
  localparam int ADDR_STEP   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                           sys_rst;
  logic                           calib_done;
  logic [NUM_WR-1:0]              wr_req;
  logic [NUM_WR*ADDR_W-1:0]       wr_addr;
  logic [NUM_WR*DATA_W-1:0]       wr_data;
  logic [NUM_WR-1:0]              wr_ack;
  logic                           rd_enable;
  logic                           refill_req;
  logic                           refill_half;
  logic                           refill_ack;
  logic                           primed;
  logic [2*HALF_WORDS*DATA_W-1:0] buf_data;
  logic                           frame_wrap;

  ddr_frame_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) app ();

  ddr_frame_arbiter #(
    .NUM_WR(NUM_WR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HALF_WORDS(HALF_WORDS),
    .FRAME_WORDS(FRAME_WORDS), .ADDR_STEP(ADDR_STEP)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .calib_done(calib_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_enable(rd_enable), .refill_req(refill_req), .refill_half(refill_half),
    .refill_ack(refill_ack), .primed(primed), .buf_data(buf_data),
    .frame_wrap(frame_wrap), .app(app)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } ret_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_toggle = 0;
  int ack_cnt = 0, ack_cyc = 0, refill_cnt = 0, wrap_cnt = 0, en_cnt = 0;
  int first_rd_cyc = -1;
  int mark;

  logic [ADDR_W-1:0] rd_q[$];
  wr_exp_t           wr_q[$];
  int                ack_q[$];
  ret_t              ret_q[$];
  logic [DATA_W-1:0] exp_buf [10];

  localparam logic [ADDR_W-1:0] A0 = 28'h0100020;
  localparam logic [ADDR_W-1:0] A1 = 28'h0200040;
  localparam logic [ADDR_W-1:0] A2 = 28'h0300080;
  localparam logic [DATA_W-1:0] D0 = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [DATA_W-1:0] D1 = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [DATA_W-1:0] D2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {4{4'hA, a}};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock of bench activity at the falling edge.
  task automatic tick();
    logic [ADDR_W-1:0] a;
    wr_exp_t           e;
    int                ch;
    @(negedge clk);
    cyc++;
    if (wr_ack != 2'b00) begin
      ack_cnt++;
      ack_cyc = cyc;
      if (ack_q.size() > 0) begin
        ch = ack_q.pop_front();
        check("wr_ack_ch", 128'(wr_ack), 128'(2'b01 << ch));
      end else begin
        check("wr_ack_unexp", 128'(wr_ack), 128'(2'b00));
      end
    end
    if (refill_ack) refill_cnt++;
    if (frame_wrap) wrap_cnt++;
    app.app_rdy     = (rdy_toggle != 0) ? ((cyc % 2) == 1) : 1'b1;
    app.app_wdf_rdy = 1'b1;
    if (app.app_en && app.app_rdy) begin
      en_cnt++;
      if (app.app_cmd == 3'b001) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (rd_q.size() > 0) begin
          a = rd_q.pop_front();
          check("rd_addr", 128'(app.app_addr), 128'(a));
        end else begin
          check("rd_unexp", 128'(app.app_en), 128'(1'b0));
        end
        ret_q.push_back('{cyc + 3, mem_word(app.app_addr)});
      end else if (app.app_cmd == 3'b000) begin
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check("wr_addr", 128'(app.app_addr), 128'(e.addr));
          check("wr_data", app.app_wdf_data, e.data);
        end else begin
          check("wr_unexp", 128'(app.app_en), 128'(1'b0));
        end
      end else begin
        check("app_cmd", 128'(app.app_cmd), 128'(3'b001));
      end
    end
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      app.app_rd_data_valid = 1'b1;
      app.app_rd_data       = ret_q[0].data;
      void'(ret_q.pop_front());
    end else begin
      app.app_rd_data_valid = 1'b0;
    end
  endtask

  task automatic check_buf();
    for (int i = 0; i < 2 * HALF_WORDS; i++) begin
      check($sformatf("buf%0d", i), buf_data[i*DATA_W +: DATA_W], exp_buf[i]);
    end
  endtask

  task automatic expect_fill(input int half, input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] a;
    a = start;
    for (int k = 0; k < HALF_WORDS; k++) begin
      rd_q.push_back(a);
      exp_buf[half*HALF_WORDS + k] = mem_word(a);
      a = (a == ADDR_W'((FRAME_WORDS - 1) * ADDR_STEP)) ? 28'd0 : a + 28'd8;
    end
  endtask

  initial begin
    sys_rst = 1'b0; calib_done = 1'b0; wr_req = 2'b11;
    wr_addr = {A1, A0}; wr_data = {D1, D0};
    rd_enable = 1'b0; refill_req = 1'b0; refill_half = 1'b0;
    app.app_rdy = 1'b1; app.app_wdf_rdy = 1'b1;
    app.app_rd_data = 128'd0; app.app_rd_data_valid = 1'b0;
    for (int i = 0; i < 10; i++) exp_buf[i] = 128'd0;

    // Reset state.
    repeat (3) tick();
    check("rst_app_en", 128'(app.app_en), 128'(1'b0));
    check("rst_wren", 128'(app.app_wdf_wren), 128'(1'b0));
    check("rst_wdf_end", 128'(app.app_wdf_end), 128'(1'b1));
    check("rst_app_addr", 128'(app.app_addr), 128'd0);
    check("rst_primed", 128'(primed), 128'(1'b0));
    check("rst_buf", buf_data[DATA_W-1:0], 128'd0);

    // Calibration not done: nothing happens.
    sys_rst = 1'b1;
    repeat (20) tick();
    check("calib_en", 128'(en_cnt), 128'd0);
    check("calib_ack", 128'(ack_cnt), 128'd0);

    // Round-robin writes with both channels requesting.
    wr_q.push_back('{A0, D0}); ack_q.push_back(0);
    wr_q.push_back('{A1, D1}); ack_q.push_back(1);
    wr_q.push_back('{A0, D0}); ack_q.push_back(0);
    calib_done = 1'b1;
    for (int i = 0; i < 200 && ack_cnt < 3; i++) tick();
    wr_req = 2'b00;
    repeat (10) tick();
    check("wr_ack_count", 128'(ack_cnt), 128'd3);
    check("wr_q_left", 128'(wr_q.size()), 128'd0);

    // Priming: half 0 then half 1, addresses 0..72.
    expect_fill(0, 28'd0);
    expect_fill(1, 28'd40);
    rd_enable = 1'b1;
    for (int i = 0; i < 300 && !primed; i++) tick();
    check("primed", 128'(primed), 128'(1'b1));
    repeat (5) tick();
    check("prime_rd_left", 128'(rd_q.size()), 128'd0);
    check("prime_refill_ack", 128'(refill_cnt), 128'd0);
    check("prime_wrap", 128'(wrap_cnt), 128'd0);
    check_buf();

    // Refill half 0 with app_rdy toggling; request held until ack.
    expect_fill(0, 28'd80);
    rdy_toggle = 1;
    refill_half = 1'b0; refill_req = 1'b1;
    for (int i = 0; i < 300 && refill_cnt == 0; i++) tick();
    refill_req = 1'b0;
    repeat (20) tick();
    rdy_toggle = 0;
    check("refill0_acks", 128'(refill_cnt), 128'd1);
    check("refill0_rd_left", 128'(rd_q.size()), 128'd0);
    check_buf();

    // Refill half 1 across the frame end: 120 then wrap to 0.
    mark = wrap_cnt;
    expect_fill(1, 28'd120);
    refill_half = 1'b1; refill_req = 1'b1;
    for (int i = 0; i < 300 && refill_cnt < 2; i++) tick();
    refill_req = 1'b0;
    repeat (10) tick();
    check("refill1_acks", 128'(refill_cnt), 128'd2);
    check("wrap_pulses", 128'(wrap_cnt - mark), 128'd1);
    check("refill1_rd_left", 128'(rd_q.size()), 128'd0);
    check_buf();

    // Refill requested while a write sits in WRITE_DONE.
    wr_addr = {A1, A2}; wr_data = {D1, D2};
    wr_q.push_back('{A2, D2}); ack_q.push_back(0);
    wr_req = 2'b01;
    mark = ack_cnt;
    for (int i = 0; i < 100 && !(app.app_en && app.app_wdf_wren); i++) tick();
    check("write_started", 128'(app.app_wdf_wren), 128'(1'b1));
    wr_req = 2'b00;
    expect_fill(0, 28'd32);
    first_rd_cyc = -1;
    refill_half = 1'b0; refill_req = 1'b1;
    for (int i = 0; i < 300 && refill_cnt < 3; i++) tick();
    refill_req = 1'b0;
    repeat (10) tick();
    check("wd_acks", 128'(ack_cnt - mark), 128'd1);
    check("wd_read_after_ack", 128'(first_rd_cyc - ack_cyc), 128'd1);
    check("wd_refill_acks", 128'(refill_cnt), 128'd3);
    check("wd_rd_left", 128'(rd_q.size()), 128'd0);
    check_buf();

    // Reset in the middle of a refill: abandoned, no ack.
    expect_fill(1, 28'd72);
    refill_half = 1'b1; refill_req = 1'b1;
    for (int i = 0; i < 100 && !app.app_en; i++) tick();
    repeat (2) tick();
    sys_rst = 1'b0;
    rd_enable = 1'b0; refill_req = 1'b0;
    mark = refill_cnt;
    repeat (3) tick();
    check("mid_rst_en", 128'(app.app_en), 128'(1'b0));
    check("mid_rst_primed", 128'(primed), 128'(1'b0));
    check("mid_rst_buf", buf_data[5*DATA_W +: DATA_W], 128'd0);
    rd_q.delete(); ret_q.delete();
    app.app_rd_data_valid = 1'b0;
    sys_rst = 1'b1;
    mark = en_cnt;
    repeat (20) tick();
    check("mid_rst_no_ack", 128'(refill_cnt), 128'(3));
    check("mid_rst_idle", 128'(en_cnt - mark), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
